doa_scan_ctrl: RTL and testbench

- Sequencer for the ULA direction-of-arrival power scan. It captures one 4-channel I/Q snapshot and sweeps the steering-vector table across all scan angles.
- For each angle it feeds the held samples to the external 4-channel power datapath and accumulates the returned |aᴴx|² per angle over 2^N_SNAP_LOG2 snapshots.
- After the last snapshot it reports the peak angle and its accumulated power.
- It sits between the ADC sample stream, the steering-vector ROM / power datapath and the result consumer.

---
 rtl/doa_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_doa_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doa_scan_ctrl.sv
// rtl/doa_scan_ctrl.sv - ULA direction-of-arrival scan sequencer
// Holds one snapshot, sweeps all steering vectors, accumulates power per angle and reports the peak.
module doa_scan_ctrl #(
  parameter int WORD_LENGTH_IN = 16,
  parameter int POWER_W        = 80,
  parameter int N_ANGLES       = 64,
  parameter int ANGLE_W        = 6,
  parameter int N_SNAP_LOG2    = 4,
  parameter int ACC_W          = POWER_W + N_SNAP_LOG2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [8*WORD_LENGTH_IN-1:0] s_iq,
  output logic [8*WORD_LENGTH_IN-1:0] x_iq,
  output logic [ANGLE_W-1:0]          sv_addr,
  output logic                        sv_rd,
  input  logic [POWER_W-1:0]          power,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ANGLE_W-1:0]          peak_angle,
  output logic [ACC_W-1:0]            peak_power
);

  typedef enum logic [1:0] {IDLE, SWEEP, RESULT} state_t;

  localparam logic [ANGLE_W-1:0]     LAST_ANGLE = ANGLE_W'(N_ANGLES - 1);
  localparam logic [N_SNAP_LOG2-1:0] LAST_SNAP  = '1;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_s_ready;
  logic [8*WORD_LENGTH_IN-1:0] r_x_iq;
  logic [ANGLE_W-1:0]          r_sv_addr;
  logic                        r_sv_rd;
  logic                        r_p_valid;
  logic [ANGLE_W-1:0]          r_p_angle;
  logic [N_SNAP_LOG2-1:0]      r_snap_cnt;
  logic                        r_res_valid;
  logic [ANGLE_W-1:0]          r_peak_angle;
  logic [ACC_W-1:0]            r_peak_power;
  logic [ANGLE_W-1:0]          r_best_angle;
  logic [ACC_W-1:0]            r_best_power;
  logic [ACC_W-1:0]            r_acc [N_ANGLES];

  logic                        w_cap;
  logic                        w_sweep_done;
  logic                        w_last_snap;
  logic [ACC_W-1:0]            w_power_ext;
  logic [ACC_W-1:0]            w_acc_upd;
  logic                        w_take;
  logic [ANGLE_W-1:0]          w_best_angle_n;
  logic [ACC_W-1:0]            w_best_power_n;

  assign w_cap        = (r_state == IDLE) && s_valid && r_s_ready;
  // The sweep ends once the last returned power has been consumed and no read is outstanding.
  assign w_sweep_done = (r_state == SWEEP) && r_p_valid && !r_sv_rd;
  assign w_last_snap  = (r_snap_cnt == LAST_SNAP);
  assign w_power_ext  = ACC_W'(power);
  assign w_acc_upd    = (r_snap_cnt == '0) ? w_power_ext : (r_acc[r_p_angle] + w_power_ext);

  // Angle 0 seeds the tracker; strict compare keeps the lowest index on ties.
  assign w_take         = w_last_snap && r_p_valid &&
                          ((r_p_angle == '0) || (w_acc_upd > r_best_power));
  assign w_best_angle_n = w_take ? r_p_angle : r_best_angle;
  assign w_best_power_n = w_take ? w_acc_upd : r_best_power;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_cap) w_state_nxt = SWEEP;
        SWEEP:   if (w_sweep_done) w_state_nxt = w_last_snap ? RESULT : IDLE;
        RESULT:  if (r_res_valid && res_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ready    <= 1'b0;
      r_x_iq       <= '0;
      r_sv_addr    <= '0;
      r_sv_rd      <= 1'b0;
      r_p_valid    <= 1'b0;
      r_p_angle    <= '0;
      r_snap_cnt   <= '0;
      r_res_valid  <= 1'b0;
      r_peak_angle <= '0;
      r_peak_power <= '0;
      r_best_angle <= '0;
      r_best_power <= '0;
    end else begin
      r_s_ready   <= (w_state_nxt == IDLE);
      r_res_valid <= (w_state_nxt == RESULT);
      if (clr) begin
        r_sv_rd    <= 1'b0;
        r_p_valid  <= 1'b0;
        r_snap_cnt <= '0;
      end else begin
        r_p_valid <= r_sv_rd;
        r_p_angle <= r_sv_addr;
        if (w_cap) begin
          r_x_iq    <= s_iq;
          r_sv_addr <= '0;
          r_sv_rd   <= 1'b1;
        end else if (r_sv_rd) begin
          if (r_sv_addr == LAST_ANGLE) begin
            r_sv_rd <= 1'b0;
          end else begin
            r_sv_addr <= r_sv_addr + ANGLE_W'(1);
          end
        end
        if (w_take) begin
          r_best_angle <= r_p_angle;
          r_best_power <= w_acc_upd;
        end
        // Peak outputs only change at frame completion so they stay stable through RESULT.
        if (w_sweep_done) begin
          if (w_last_snap) begin
            r_snap_cnt   <= '0;
            r_peak_angle <= w_best_angle_n;
            r_peak_power <= w_best_power_n;
          end else begin
            r_snap_cnt <= r_snap_cnt + N_SNAP_LOG2'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_p_valid && !clr) begin
      r_acc[r_p_angle] <= w_acc_upd;
    end
  end

  assign s_ready    = r_s_ready;
  assign x_iq       = r_x_iq;
  assign sv_addr    = r_sv_addr;
  assign sv_rd      = r_sv_rd;
  assign res_valid  = r_res_valid;
  assign peak_angle = r_peak_angle;
  assign peak_power = r_peak_power;

endmodule

// File: tb/tb_doa_scan_ctrl.sv
// tb/tb_doa_scan_ctrl.sv - scoreboard bench for doa_scan_ctrl
module tb_doa_scan_ctrl;
  localparam int WL    = 16;
  localparam int PW    = 80;
  localparam int NA    = 8;
  localparam int AW    = 3;
  localparam int SL    = 2;
  localparam int AC    = PW + SL;
  localparam int SLW   = 4;
  localparam int ACW   = PW + SLW;
  localparam int NSNAP = 1 << SL;

  logic clk = 1'b0;
  logic rst, clr, s_valid, s_ready, sv_rd, res_valid, res_ready;
  logic [8*WL-1:0] s_iq, x_iq;
  logic [AW-1:0]   sv_addr, peak_angle;
  logic [PW-1:0]   power;
  logic [AC-1:0]   peak_power;

  logic s_valid_w, s_ready_w, sv_rd_w, res_valid_w, res_ready_w, clr_w;
  logic [8*WL-1:0] s_iq_w, x_iq_w;
  logic [AW-1:0]   sv_addr_w, peak_angle_w;
  logic [PW-1:0]   power_w;
  logic [ACW-1:0]  peak_power_w;

  typedef struct packed {
    logic [AW-1:0]  ang;
    logic [ACW-1:0] pw;
  } res_t;

  logic [PW-1:0] tbl [NA];
  logic [PW-1:0] ptab [NSNAP][NA];
  res_t q_d[$];
  res_t q_w[$];
  res_t mon_e;
  logic [8*WL-1:0] last_iq;
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) power <= tbl[sv_addr];
  assign power_w = '1;

  doa_scan_ctrl #(.WORD_LENGTH_IN(WL), .POWER_W(PW), .N_ANGLES(NA), .ANGLE_W(AW),
                  .N_SNAP_LOG2(SL)) u_d (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready), .s_iq(s_iq),
    .x_iq(x_iq), .sv_addr(sv_addr), .sv_rd(sv_rd), .power(power), .res_valid(res_valid),
    .res_ready(res_ready), .peak_angle(peak_angle), .peak_power(peak_power));

  doa_scan_ctrl #(.WORD_LENGTH_IN(WL), .POWER_W(PW), .N_ANGLES(NA), .ANGLE_W(AW),
                  .N_SNAP_LOG2(SLW)) u_w (
    .clk(clk), .rst(rst), .clr(clr_w), .s_valid(s_valid_w), .s_ready(s_ready_w), .s_iq(s_iq_w),
    .x_iq(x_iq_w), .sv_addr(sv_addr_w), .sv_rd(sv_rd_w), .power(power_w), .res_valid(res_valid_w),
    .res_ready(res_ready_w), .peak_angle(peak_angle_w), .peak_power(peak_power_w));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: per-angle sum over the frame's snapshots, first maximum wins.
  function automatic res_t model();
    logic [ACW-1:0] acc;
    res_t r;
    r = '0;
    for (int a = 0; a < NA; a++) begin
      acc = '0;
      for (int s = 0; s < NSNAP; s++) acc = acc + ACW'(ptab[s][a]);
      if (a == 0 || acc > r.pw) begin
        r.ang = AW'(a);
        r.pw  = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] rnd_pw();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) return w[PW-1:0];
    return PW'($urandom_range(0, 15));
  endfunction

  task automatic fill_random();
    for (int s = 0; s < NSNAP; s++)
      for (int a = 0; a < NA; a++) ptab[s][a] = rnd_pw();
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int n;
    n = 0;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    ok = s_ready;
    if (!ok) chk(name, 0, 1);
  endtask

  task automatic snapshot(input int s, input bit check_gap, inout int last_cap);
    bit ok;
    logic [8*WL-1:0] v;
    s_valid = 1'b1;
    wait_ready("timeout_s_ready", ok);
    if (!ok) return;
    if (s > 0) chk("x_iq_held_through_sweep", x_iq, last_iq);
    for (int a = 0; a < NA; a++) tbl[a] = ptab[s][a];
    v = {$urandom, $urandom, $urandom, $urandom};
    s_iq = v;
    tick();
    chk("x_iq_capture", x_iq, v);
    chk("s_ready_low_after_capture", s_ready, 0);
    if (check_gap) chk("s_ready_period", cyc - last_cap, NA + 2);
    last_cap = cyc;
    last_iq  = v;
    s_iq = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic frame(input bit b2b, input bit rr_early, input int hold);
    int lc, n, bad;
    logic [AW-1:0] pa;
    logic [AC-1:0] pp;
    lc = 0;
    q_d.push_back(model());
    for (int s = 0; s < NSNAP; s++) begin
      snapshot(s, b2b && (s > 0), lc);
      if (s == NSNAP - 1) s_valid = 1'b0;
      else if (!b2b) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 12)) tick();
      end
    end
    res_ready = rr_early;
    n = 0;
    while (!res_valid && n < 60) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      chk("timeout_res_valid", 0, 1);
      return;
    end
    chk("res_latency", cyc - lc + 1, NA + 2);
    if (!rr_early) begin
      pa  = peak_angle;
      pp  = peak_power;
      bad = 0;
      repeat (hold) begin
        tick();
        if (!res_valid || peak_angle !== pa || peak_power !== pp || s_ready) bad++;
      end
      chk("backpressure_stable", bad, 0);
      res_ready = 1'b1;
    end
    tick();
    res_ready = 1'b0;
    chk("s_ready_after_result", s_ready, 1);
    chk("res_valid_cleared", res_valid, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (q_d.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        mon_e = q_d.pop_front();
        chk("peak_angle", peak_angle, mon_e.ang);
        chk("peak_power", peak_power, mon_e.pw);
      end
    end
    if (!rst && res_valid_w && res_ready_w) begin
      if (q_w.size() == 0) chk("unexpected_result_w", 1, 0);
      else begin
        mon_e = q_w.pop_front();
        chk("peak_angle_w", peak_angle_w, mon_e.ang);
        chk("peak_power_w", peak_power_w, mon_e.pw);
      end
    end
  end

  initial begin
    int lc, n;
    logic [ACW-1:0] ew;
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_iq = '0; res_ready = 1'b0;
    s_valid_w = 1'b0; s_iq_w = '0; res_ready_w = 1'b0; clr_w = 1'b0;
    last_iq = '0;
    for (int a = 0; a < NA; a++) tbl[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_sv_rd", sv_rd, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_outputs", {x_iq, sv_addr, peak_angle, peak_power}, 0);
    rst = 1'b0;
    tick();
    chk("release_s_ready", s_ready, 1);

    for (int s = 0; s < NSNAP; s++)
      for (int a = 0; a < NA; a++) ptab[s][a] = (a == 5) ? PW'(11) : PW'(1);
    frame(1'b1, 1'b0, 2);

    // Asynchronous reset in the middle of a sweep.
    lc = 0;
    snapshot(0, 1'b0, lc);
    s_valid = 1'b0;
    repeat (3) tick();
    chk("mid_sweep_sv_rd", sv_rd, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {s_ready, sv_rd, res_valid}, 0);
    chk("async_rst_data", {x_iq, sv_addr, peak_angle, peak_power}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rerelease_s_ready", s_ready, 1);
    chk("rerelease_res_valid", res_valid, 0);

    for (int s = 0; s < NSNAP; s++)
      for (int a = 0; a < NA; a++) ptab[s][a] = (a == 2 || a == 6) ? PW'(9) : PW'(0);
    frame(1'b0, 1'b1, 0);

    fill_random();
    frame(1'b1, 1'b0, 20);
    for (int s = 0; s < NSNAP; s++)
      for (int a = 0; a < NA; a++) ptab[s][a] = PW'(3);
    frame(1'b0, 1'b1, 0);

    // Abort during angle 3 of the second snapshot.
    fill_random();
    snapshot(0, 1'b0, lc);
    s_valid = 1'b0;
    snapshot(1, 1'b0, lc);
    s_valid = 1'b0;
    n = 0;
    while (sv_addr != AW'(3) && n < 20) begin
      tick();
      n++;
    end
    chk("clr_reach_k3", sv_addr, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_idle_s_ready", s_ready, 1);
    chk("clr_sv_rd", sv_rd, 0);
    chk("clr_res_valid", res_valid, 0);
    repeat (12) tick();
    chk("clr_no_result", res_valid, 0);
    fill_random();
    frame(1'b0, 1'b0, 3);

    for (int f = 0; f < 6; f++) begin
      fill_random();
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 5));
    end

    // Full-scale power on every angle over 16 snapshots.
    ew = '0;
    for (int s = 0; s < (1 << SLW); s++) ew = ew + ACW'({PW{1'b1}});
    q_w.push_back('{ang: AW'(0), pw: ew});
    s_valid_w = 1'b1;
    n = 0;
    while (!res_valid_w && n < 400) begin
      s_iq_w = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    s_valid_w = 1'b0;
    chk("wide_res_valid", res_valid_w, 1);
    res_ready_w = 1'b1;
    tick();
    res_ready_w = 1'b0;
    chk("wide_res_cleared", res_valid_w, 0);

    repeat (3) tick();
    chk("scoreboard_drained", q_d.size() + q_w.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
